// File: rtl/i_decoder_n_pulse_pkg.sv
// Shared definitions for the active-low pulsed decoder: FSM states, counter
// sizing helper and the all-ones idle pattern.
package i_decoder_n_pulse_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Floor of log2; flog2(1) = 0.
    function automatic int flog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) > 1) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Lower 2**size bits set; callers truncate to their output width.
    function automatic logic [63:0] idle_ones(input int size);
        return (64'd1 << (1 << size)) - 64'd1;
    endfunction

endpackage

// File: rtl/i_decoder_n_pulse_core.sv
// Combinational inverted-code to active-low one-hot decoder.
module i_decoder_n_pulse_core
    import i_decoder_n_pulse_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0]      code_n,
    output logic [2**SIZE-1:0]   onehot_n
);

    logic [SIZE-1:0] idx;

    assign idx = ~code_n;

    for (genvar gi = 0; gi < 2**SIZE; gi++) begin : g_bit
        assign onehot_n[gi] = (idx != SIZE'(gi));
    end

endmodule

// File: rtl/i_decoder_n_pulse.sv
// Handshaked inverted-code decoder that drives a registered active-low one-hot
// strobe for HOLD cycles, with a one-entry buffer for bubble-free streaming.
module i_decoder_n_pulse
    import i_decoder_n_pulse_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_code_n,
    output logic [2**SIZE-1:0]   out_n,
    output logic                 busy,
    output logic                 done
);

    localparam int              W        = 2**SIZE;
    localparam int              CW       = flog2(HOLD) + 1;
    localparam logic [W-1:0]    IDLE_N   = W'(idle_ones(SIZE));
    localparam logic [CW-1:0]   RELOAD   = CW'(HOLD - 1);
    localparam logic            ONE_SHOT = (HOLD == 1);

    state_t            state_reg;
    logic [W-1:0]      out_n_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [SIZE-1:0]   buf_reg;
    logic              buf_full_reg;
    logic [CW-1:0]     cnt_reg;

    logic              xfer;
    logic [SIZE-1:0]   dec_src;
    logic [W-1:0]      dec_n;

    assign in_ready = ~buf_full_reg & ~rst;
    assign xfer     = in_valid & in_ready;

    // One decoder serves both load paths; a full buffer always has priority.
    assign dec_src  = buf_full_reg ? buf_reg : in_code_n;

    i_decoder_n_pulse_core #(
        .SIZE (SIZE)
    ) u_core (
        .code_n   (dec_src),
        .onehot_n (dec_n)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            out_n_reg    <= IDLE_N;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        out_n_reg <= dec_n;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= RELOAD;
                        done_reg  <= ONE_SHOT;
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg  <= cnt_reg - CW'(1);
                        done_reg <= (cnt_reg == CW'(1));
                        if (xfer) begin
                            buf_reg      <= in_code_n;
                            buf_full_reg <= 1'b1;
                        end
                    end else if (buf_full_reg) begin
                        out_n_reg    <= dec_n;
                        cnt_reg      <= RELOAD;
                        done_reg     <= ONE_SHOT;
                        buf_full_reg <= 1'b0;
                    end else if (xfer) begin
                        // Last cycle with nothing queued: pass the new code straight through.
                        out_n_reg <= dec_n;
                        cnt_reg   <= RELOAD;
                        done_reg  <= ONE_SHOT;
                    end else begin
                        out_n_reg <= IDLE_N;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_n = out_n_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_i_decoder_n_pulse.sv
// Bench for i_decoder_n_pulse: directed vector table, queue-based random
// reference model (SIZE=2, HOLD=2) and a HOLD=1, SIZE=3 streaming sequence.
module tb_i_decoder_n_pulse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, busy, done;
    logic [1:0] in_code_n;
    logic [3:0] out_n;

    logic       rst1, in_valid1, in_ready1, busy1, done1;
    logic [2:0] in_code_n1;
    logic [7:0] out_n1;

    i_decoder_n_pulse #(.SIZE(2), .HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code_n (in_code_n),
        .out_n     (out_n),
        .busy      (busy),
        .done      (done)
    );

    i_decoder_n_pulse #(.SIZE(3), .HOLD(1)) dut_h1 (
        .clk       (clk),
        .rst       (rst1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_code_n (in_code_n1),
        .out_n     (out_n1),
        .busy      (busy1),
        .done      (done1)
    );

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] code;
        logic       ready;   // expected before the edge
        logic [3:0] out_n;   // expected after the edge
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [1:0] c,
                       input logic rd, input logic [3:0] o, input logic b, input logic d);
        vec_t t;
        t.rst = r; t.valid = v; t.code = c; t.ready = rd;
        t.out_n = o; t.busy = b; t.done = d;
        tbl.push_back(t);
    endtask

    // Reference model: queue of accepted codes; head is the code on display.
    int q[$];
    int elapsed;
    localparam int HOLD_M = 2;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code_n = '0;
        rst1 = 1'b1; in_valid1 = 1'b0; in_code_n1 = '0;

        // reset held with valid asserted
        add(1, 1, 2'b00, 0, 4'b1111, 0, 0);
        add(1, 1, 2'b00, 0, 4'b1111, 0, 0);
        add(1, 1, 2'b00, 0, 4'b1111, 0, 0);
        // single code 10 -> index 1
        add(0, 1, 2'b10, 1, 4'b1101, 1, 0);
        add(0, 0, 2'b00, 1, 4'b1101, 1, 1);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        // back-to-back 11, 00, 01
        add(0, 1, 2'b11, 1, 4'b1110, 1, 0);
        add(0, 1, 2'b00, 1, 4'b1110, 1, 1);
        add(0, 1, 2'b01, 0, 4'b0111, 1, 0);
        add(0, 1, 2'b01, 1, 4'b0111, 1, 1);
        add(0, 0, 2'b00, 0, 4'b1011, 1, 0);
        add(0, 0, 2'b00, 1, 4'b1011, 1, 1);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        // buffer stall: 11, then 10 buffered, 01 held until accepted
        add(0, 1, 2'b11, 1, 4'b1110, 1, 0);
        add(0, 1, 2'b10, 1, 4'b1110, 1, 1);
        add(0, 1, 2'b01, 0, 4'b1101, 1, 0);
        add(0, 1, 2'b01, 1, 4'b1101, 1, 1);
        add(0, 0, 2'b00, 0, 4'b1011, 1, 0);
        add(0, 0, 2'b00, 1, 4'b1011, 1, 1);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        // reset while strobing 1101 with buffer full
        add(0, 1, 2'b10, 1, 4'b1101, 1, 0);
        add(0, 1, 2'b00, 1, 4'b1101, 1, 1);
        add(1, 1, 2'b00, 0, 4'b1111, 0, 0);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);
        add(0, 0, 2'b00, 1, 4'b1111, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; in_valid = tbl[i].valid; in_code_n = tbl[i].code;
            #1;
            chk("tbl_ready", i, 32'(in_ready), 32'(tbl[i].ready));
            @(posedge clk);
            #1;
            chk("tbl_out_n", i, 32'(out_n), 32'(tbl[i].out_n));
            chk("tbl_busy",  i, 32'(busy),  32'(tbl[i].busy));
            chk("tbl_done",  i, 32'(done),  32'(tbl[i].done));
        end

        // randomized traffic against the queue model
        q.delete();
        elapsed = 0;
        for (int i = 0; i < 400; i++) begin
            logic       r, v, rdy, xfer;
            logic [1:0] c;
            logic [3:0] exp_o;
            int         idx;
            r = (i == 0) || ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = 2'($urandom);
            @(negedge clk);
            rst = r; in_valid = v; in_code_n = c;
            rdy  = !r && (q.size() < 2);
            xfer = v && rdy;
            #1;
            chk("rnd_ready", i, 32'(in_ready), 32'(rdy));
            @(posedge clk);
            if (r) begin
                q.delete();
                elapsed = 0;
            end else begin
                if (q.size() > 0) begin
                    elapsed++;
                    if (elapsed == HOLD_M) begin
                        void'(q.pop_front());
                        elapsed = 0;
                    end
                end
                if (xfer) q.push_back(int'(c));
            end
            #1;
            if (q.size() > 0) begin
                idx   = (~q[0]) & 3;
                exp_o = ~(4'd1 << idx);
            end else begin
                exp_o = 4'b1111;
            end
            chk("rnd_out_n", i, 32'(out_n), 32'(exp_o));
            chk("rnd_busy",  i, 32'(busy),  32'(q.size() > 0));
            chk("rnd_done",  i, 32'(done),  32'((q.size() > 0) && (elapsed == HOLD_M - 1)));
        end

        // HOLD=1, SIZE=3: all eight codes streamed back-to-back
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        rst1 = 1'b0; in_valid1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            int         idx;
            @(negedge clk);
            in_valid1 = 1'b1; in_code_n1 = k[2:0];
            #1;
            chk("h1_ready", k, 32'(in_ready1), 32'd1);
            @(posedge clk);
            #1;
            idx = (~k) & 7;
            e   = 8'd1 << idx;
            e   = ~e;
            chk("h1_out_n", k, 32'(out_n1), 32'(e));
            chk("h1_done",  k, 32'(done1),  32'd1);
            chk("h1_busy",  k, 32'(busy1),  32'd1);
        end
        @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("h1_idle_out_n", 8, 32'(out_n1), 32'hFF);
        chk("h1_idle_done",  8, 32'(done1),  32'd0);
        chk("h1_idle_busy",  8, 32'(busy1),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
